// File: rtl/xorshift_checker_pkg.sv
// Shared types, constants and the xorshift32 step used by the stream checker.
// Build option: XORSHIFT_CHECKER_RESEED_EN (see xorshift_checker.sv).
package xorshift_checker_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  typedef logic [31:0] word_t;

  // Reset seed of the matching generator
  localparam word_t XS_SEED = 32'h92D68CA2;

  // Step lanes: one predicts from the received word, one from the prediction
  localparam int NUM_LANES = 2;
  localparam int LANE_DIN  = 0;
  localparam int LANE_EXP  = 1;

  function automatic word_t xs_next(input word_t y);
    word_t t0, t1;
    t0 = y ^ (y << 13);
    t1 = t0 ^ (t0 >> 17);
    return t1 ^ (t1 << 5);
  endfunction

endpackage

// File: rtl/xorshift_checker_step.sv
// Combinational xorshift32 step, one instance per prediction lane.
module xorshift_step
  import xorshift_checker_pkg::*;
(
  input  logic [31:0] y,
  output logic [31:0] ny
);

  assign ny = xs_next(y);

endmodule

// File: rtl/xorshift_checker.sv
// Synchroniser/error checker for a received xorshift32 word stream.
// Define XORSHIFT_CHECKER_RESEED_EN to reseed the predictor from a nonzero bad word while locked.
module xorshift_checker
  import xorshift_checker_pkg::*;
#(
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      din,
  input  logic             din_valid,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [31:0]      expected
);

  localparam int RUN_W  = $clog2(LOCK_N + 1);
  localparam int MISS_W = $clog2(LOSS_N + 1);

  logic [NUM_LANES-1:0][31:0] step_in, step_out;

  assign step_in[LANE_DIN] = din;
  assign step_in[LANE_EXP] = expected;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_step
    xorshift_step u_step (
      .y  (step_in[l]),
      .ny (step_out[l])
    );
  end

  word_t nx_din, nx_exp, relock_exp;
  assign nx_din = step_out[LANE_DIN];
  assign nx_exp = step_out[LANE_EXP];

`ifdef XORSHIFT_CHECKER_RESEED_EN
  // A nonzero bad word is taken as the new phase; zero would freeze the predictor
  assign relock_exp = (|din) ? nx_din : nx_exp;
`else
  assign relock_exp = nx_exp;
`endif

  state_t            state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [CNT_W-1:0]  cnt_d;
  word_t             exp_d;
  logic              err_d, lock_d;
  logic              match, din_nz, cnt_sat;

  assign match   = (din == expected);
  assign din_nz  = |din;
  assign cnt_sat = &err_count;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    miss_d  = miss_q;
    exp_d   = expected;
    cnt_d   = err_count;
    err_d   = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        SEARCH: begin
          if (din_nz) begin
            exp_d   = nx_din;
            run_d   = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (match) begin
            exp_d = nx_din;
            if (run_q == RUN_W'(LOCK_N - 1)) begin
              state_d = LOCKED;
              run_d   = '0;
              miss_d  = '0;
            end else begin
              run_d = run_q + 1'b1;
            end
          end else if (din_nz) begin
            exp_d = nx_din;
            run_d = '0;
          end else begin
            state_d = SEARCH;
            run_d   = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            exp_d  = nx_exp;
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            exp_d = relock_exp;
            if (!cnt_sat) cnt_d = err_count + CNT_W'(1);
            if (miss_q == MISS_W'(LOSS_N - 1)) begin
              state_d = SEARCH;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = SEARCH;
          run_d   = '0;
          miss_d  = '0;
        end
      endcase
    end
    lock_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SEARCH;
      run_q     <= '0;
      miss_q    <= '0;
      expected  <= '0;
      err_count <= '0;
      err       <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      miss_q    <= miss_d;
      expected  <= exp_d;
      err_count <= cnt_d;
      err       <= err_d;
      locked    <= lock_d;
    end
  end

endmodule

// File: tb/tb_xorshift_checker.sv
// Bench for xorshift_checker: default instance plus a small-counter/long-loss instance, both
// checked every cycle against a behavioural stream model, with directed literal checks.
module tb_xorshift_checker;

  localparam logic [31:0] SEED = 32'h92D68CA2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;

  logic        locked0, err0, locked1, err1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  logic [31:0] exp0, exp1;

  always #5 clk = ~clk;

  xorshift_checker dut0 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .locked(locked0), .err(err0), .err_count(cnt0), .expected(exp0)
  );

  xorshift_checker #(.LOCK_N(4), .LOSS_N(8), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .locked(locked1), .err(err1), .err_count(cnt1), .expected(exp1)
  );

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  function automatic logic [31:0] nx(input logic [31:0] y);
    logic [31:0] a, b;
    a = y ^ {y[18:0], 13'b0};
    b = a ^ {17'b0, a[31:17]};
    return b ^ {b[26:0], 5'b0};
  endfunction

  // Stream model: mode 0 hunting, 1 confirming, 2 synchronised
  int          lockn [2] = '{4, 4};
  int          lossn [2] = '{3, 8};
  int          cmax  [2] = '{65535, 3};
  int          mode  [2];
  int          mrun  [2];
  int          mmiss [2];
  int          mcnt  [2];
  bit          merr  [2];
  logic [31:0] mexp  [2];

  task automatic model_tick();
    for (int i = 0; i < 2; i++) begin
      merr[i] = 1'b0;
      if (reset) begin
        mode[i] = 0; mrun[i] = 0; mmiss[i] = 0; mcnt[i] = 0; mexp[i] = '0;
      end else if (din_valid) begin
        if (mode[i] == 0) begin
          if (din != 0) begin mexp[i] = nx(din); mode[i] = 1; mrun[i] = 0; end
        end else if (mode[i] == 1) begin
          if (din == mexp[i]) begin
            mexp[i] = nx(din);
            mrun[i]++;
            if (mrun[i] == lockn[i]) begin mode[i] = 2; mmiss[i] = 0; end
          end else if (din != 0) begin
            mexp[i] = nx(din); mrun[i] = 0;
          end else begin
            mode[i] = 0; mrun[i] = 0;
          end
        end else begin
          if (din == mexp[i]) begin
            mexp[i] = nx(mexp[i]); mmiss[i] = 0;
          end else begin
            merr[i] = 1'b1;
            if (mcnt[i] < cmax[i]) mcnt[i]++;
`ifdef XORSHIFT_CHECKER_RESEED_EN
            mexp[i] = (din != 0) ? nx(din) : nx(mexp[i]);
`else
            mexp[i] = nx(mexp[i]);
`endif
            mmiss[i]++;
            if (mmiss[i] == lossn[i]) begin mode[i] = 0; mmiss[i] = 0; mrun[i] = 0; end
          end
        end
      end
    end
  endtask

  always @(posedge clk) model_tick();

  always @(negedge clk) begin
    if (chk_en) begin
      nvec++;
      if (locked0 !== (mode[0] == 2) || err0 !== merr[0] || int'(cnt0) != mcnt[0] || exp0 !== mexp[0]) begin
        nerr++;
        $display("FAIL dut0 t=%0t got locked=%b err=%b cnt=%0d exp=%h want locked=%b err=%b cnt=%0d exp=%h",
                 $time, locked0, err0, cnt0, exp0, mode[0] == 2, merr[0], mcnt[0], mexp[0]);
      end
      nvec++;
      if (locked1 !== (mode[1] == 2) || err1 !== merr[1] || int'(cnt1) != mcnt[1] || exp1 !== mexp[1]) begin
        nerr++;
        $display("FAIL dut1 t=%0t got locked=%b err=%b cnt=%0d exp=%h want locked=%b err=%b cnt=%0d exp=%h",
                 $time, locked1, err1, cnt1, exp1, mode[1] == 2, merr[1], mcnt[1], mexp[1]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s got %h want %h", name, act, req);
    end
  endtask

  logic [31:0] g;

  task automatic drive(input logic v, input logic [31:0] d);
    din_valid = v;
    din = d;
    @(negedge clk);
  endtask

  task automatic send_good();
    drive(1'b1, g);
    g = nx(g);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, '0);
    reset = 1'b0;
    g = SEED;
  endtask

  task automatic lock_up();
    do_reset();
    for (int i = 0; i < 10; i++) send_good();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    check("reset_locked", {31'b0, locked0}, 32'd0);
    check("reset_err", {31'b0, err0}, 32'd0);
    check("reset_cnt", {16'b0, cnt0}, 32'd0);
    check("reset_exp", exp0, 32'd0);
    check("model_pin_next1", nx(32'h1), 32'h00042021);

    // Zero words never seed the search
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h0);
    check("zero_search_locked", {31'b0, locked0}, 32'd0);
    check("zero_search_exp", exp0, 32'd0);

    // Seed plus one match
    drive(1'b1, 32'h1);
    drive(1'b1, 32'h00042021);
    check("verify_run1_locked", {31'b0, locked0}, 32'd0);
    check("verify_run1_exp", exp0, nx(32'h00042021));

    // Lock from the generator seed: rises on word 5
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      send_good();
      if (i == 4) check("lock_w4", {31'b0, locked0}, 32'd0);
      if (i == 5) check("lock_w5", {31'b0, locked0}, 32'd1);
    end
    check("lock_cnt", {16'b0, cnt0}, 32'd0);

    // Invalid gaps while locked hold everything
    for (int i = 0; i < 4; i++) drive(1'b0, $urandom);
    check("gap_locked", {31'b0, locked0}, 32'd1);
    check("gap_exp", exp0, g);

    // Single-bit corruption
    drive(1'b1, g ^ 32'h1);
    g = nx(g);
    check("flip_err", {31'b0, err0}, 32'd1);
    check("flip_cnt", {16'b0, cnt0}, 32'd1);
    check("flip_locked", {31'b0, locked0}, 32'd1);
    for (int i = 0; i < 3; i++) send_good();
`ifndef XORSHIFT_CHECKER_RESEED_EN
    check("flip_after_err", {31'b0, err0}, 32'd0);
    check("flip_after_cnt", {16'b0, cnt0}, 32'd1);
`endif

    // Three bad words drop lock, clean stream relocks after five
    lock_up();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'hDEADBEEF);
      g = nx(g);
      check("bad_err", {31'b0, err0}, 32'd1);
      if (i < 3) check("bad_still_locked", {31'b0, locked0}, 32'd1);
    end
    check("bad_dropped", {31'b0, locked0}, 32'd0);
    check("bad_cnt", {16'b0, cnt0}, 32'd3);
    for (int i = 1; i <= 5; i++) begin
      send_good();
      if (i == 4) check("relock_w4", {31'b0, locked0}, 32'd0);
    end
    check("relock_w5", {31'b0, locked0}, 32'd1);
    check("relock_cnt", {16'b0, cnt0}, 32'd3);

    // Saturation on the 2-bit counter, then reset beats a valid beat
    lock_up();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, g ^ 32'h10);
      g = nx(g);
    end
    check("sat_cnt", {30'b0, cnt1}, 32'd3);
    check("sat_locked", {31'b0, locked1}, 32'd1);
    reset = 1'b1;
    drive(1'b1, g);
    reset = 1'b0;
    check("rst_locked", {31'b0, locked1}, 32'd0);
    check("rst_err", {31'b0, err1}, 32'd0);
    check("rst_cnt", {30'b0, cnt1}, 32'd0);
    check("rst_exp", exp1, 32'd0);

    // Randomised traffic against the model
    g = SEED;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        reset = 1'b1; drive(1'b1, $urandom); reset = 1'b0;
      end else if (r < 14) drive(1'b0, $urandom);
      else if (r < 18) drive(1'b1, 32'h0);
      else if (r < 23) drive(1'b1, $urandom);
      else if (r < 27) begin
        drive(1'b1, g ^ (32'h1 << $urandom_range(0, 31)));
        g = nx(g);
      end else if (r < 28) begin
        g = $urandom | 32'h1;
        send_good();
      end else send_good();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
